// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and instruction-memory-side signal bundle for icache
interface icache_if;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  // Cache view: takes the PC and the memory response, drives the fetch result and the memory request.
  modport slave (
    input  PC,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT,
    output INSTRUCTION,
    output BUSYWAIT,
    output MEM_READ,
    output MEM_ADDRESS
  );

  // Environment view: program counter plus instruction memory.
  modport master (
    output PC,
    output MEM_READDATA,
    output MEM_BUSYWAIT,
    input  INSTRUCTION,
    input  BUSYWAIT,
    input  MEM_READ,
    input  MEM_ADDRESS
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, 8 blocks x 16 bytes
module icache (
  input  logic     CLK,
  input  logic     RESET,
  icache_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t       state;
  logic         first_q;       // high during the first FETCH cycle, which never exits
  logic         mem_read_q;
  logic [5:0]   mem_addr_q;
  logic [127:0] fill_q;        // block captured from memory, written into the store in UPDATE

  logic [7:0]   valid_q;
  logic [2:0]   tag_q  [8];
  logic [127:0] data_q [8];

  logic [2:0]   pc_tag;
  logic [2:0]   pc_index;
  logic [1:0]   pc_word;
  logic [5:0]   pc_block;
  logic         hit;
  logic [127:0] sel_block;
  logic         fill_ready;
  logic         unused_pc_bits;

  assign pc_tag         = bus.PC[9:7];
  assign pc_index       = bus.PC[6:4];
  assign pc_word        = bus.PC[3:2];
  assign pc_block       = bus.PC[9:4];
  assign unused_pc_bits = ^{bus.PC[31:10], bus.PC[1:0]};

  assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign sel_block  = data_q[pc_index];
  assign fill_ready = (state == FETCH) && !first_q && !bus.MEM_BUSYWAIT;

  // Word select within the indexed block; only meaningful when hit is high.
  always_comb begin
    bus.INSTRUCTION = sel_block[31:0];
    case (pc_word)
      2'd0: bus.INSTRUCTION = sel_block[31:0];
      2'd1: bus.INSTRUCTION = sel_block[63:32];
      2'd2: bus.INSTRUCTION = sel_block[95:64];
      2'd3: bus.INSTRUCTION = sel_block[127:96];
      default: bus.INSTRUCTION = sel_block[31:0];
    endcase
  end

  // Stall follows the live hit in IDLE so hits cost nothing; any miss state holds it high.
  always_comb begin
    bus.BUSYWAIT = 1'b1;
    if (RESET)
      bus.BUSYWAIT = 1'b0;
    else if (state == IDLE)
      bus.BUSYWAIT = !hit;
  end

  // Memory request is registered so it only moves after a clock edge; reset silences it at once.
  assign bus.MEM_READ    = mem_read_q && !RESET;
  assign bus.MEM_ADDRESS = RESET ? 6'd0 : mem_addr_q;

  // Miss sequencing: IDLE detects, FETCH waits on memory, UPDATE installs the block and its valid bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      valid_q    <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      first_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state      <= FETCH;
            mem_read_q <= 1'b1;
            mem_addr_q <= pc_block;
            first_q    <= 1'b1;
          end
        end
        FETCH: begin
          first_q <= 1'b0;
          if (fill_ready) begin
            state      <= UPDATE;
            mem_read_q <= 1'b0;
          end
        end
        UPDATE: begin
          valid_q[pc_index] <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          state      <= IDLE;
          mem_read_q <= 1'b0;
          first_q    <= 1'b0;
        end
      endcase
    end
  end

  // Block capture and store writes; tag and data need no reset because valid gates every hit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill_ready)
        fill_q <= bus.MEM_READDATA;
      if (state == UPDATE) begin
        data_q[pc_index] <= fill_q;
        tag_q[pc_index]  <= pc_tag;
      end
    end
  end

endmodule
